// File: rtl/scpu_pkg.sv
// Shared opcodes, ALU/write-back select codes and FSM state encoding for the sCPU sequencer.
package scpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_B   = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_HALT
    } state_e;

endpackage

// File: rtl/scpu_decode.sv
// Combinational opcode decoder: classifies the instruction nibble and produces datapath selects.
module scpu_decode
    import scpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       two_byte,
    output logic       writes_reg,
    output logic       is_alu,
    output logic       is_jmp,
    output logic       is_bz,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        two_byte   = 1'b0;
        writes_reg = 1'b0;
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_bz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD: begin
                alu_op     = ALU_ADD;
                is_alu     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SUB: begin
                alu_op     = ALU_SUB;
                is_alu     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                is_alu     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_OR: begin
                alu_op     = ALU_OR;
                is_alu     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_MOV: begin
                wb_sel     = WB_B;
                writes_reg = 1'b1;
            end
            OP_LDI: begin
                wb_sel     = WB_IMM;
                writes_reg = 1'b1;
                two_byte   = 1'b1;
            end
            OP_JMP: begin
                two_byte = 1'b1;
                is_jmp   = 1'b1;
            end
            OP_BZ: begin
                two_byte = 1'b1;
                is_bz    = 1'b1;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                // 9..E execute as NOP but are flagged
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/scpu_ctrl_fsm.sv
// sCPU fetch/decode/execute sequencer owning PC, IR, immediate and zero flag.
// Optional SCPU_RETIRE_TRACE_EN adds a retire pulse and 16-bit retired-instruction counter.
module scpu_ctrl_fsm
    import scpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    input  logic            alu_zero,
    output logic [1:0]      rs1,
    output logic [1:0]      rs2,
    output logic [1:0]      rd,
    output logic [1:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic [7:0]      imm,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
`ifdef SCPU_RETIRE_TRACE_EN
    ,
    output logic            retire,
    output logic [15:0]     retire_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      imm_q, imm_d;
    logic            zero_q, zero_d;
    logic [PC_W-1:0] jump_target;
    logic            in_exec;

    logic [1:0] dec_alu_op;
    logic [1:0] dec_wb_sel;
    logic       dec_two_byte;
    logic       dec_writes_reg;
    logic       dec_is_alu;
    logic       dec_is_jmp;
    logic       dec_is_bz;
    logic       dec_is_halt;
    logic       dec_is_illegal;

    scpu_decode u_decode (
        .opcode     (ir_q[7:4]),
        .alu_op     (dec_alu_op),
        .wb_sel     (dec_wb_sel),
        .two_byte   (dec_two_byte),
        .writes_reg (dec_writes_reg),
        .is_alu     (dec_is_alu),
        .is_jmp     (dec_is_jmp),
        .is_bz      (dec_is_bz),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    generate
        if (PC_W <= 8) begin : g_narrow_pc
            assign jump_target = imm_q[PC_W-1:0];
        end else begin : g_wide_pc
            assign jump_target = {{(PC_W-8){1'b0}}, imm_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_is_halt) begin
                    state_d = S_HALT;
                end else if (dec_two_byte) begin
                    state_d = S_FETCH_IMM;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_FETCH_IMM: begin
                if (imem_ack) begin
                    imm_d   = imem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_is_alu) begin
                    zero_d = alu_zero;
                end
                // pc already points past the immediate; a taken jump replaces it
                if (dec_is_jmp || (dec_is_bz && zero_q)) begin
                    pc_d = jump_target;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state so alu_zero cannot loop back into them
    assign in_exec   = (state_q == S_EXEC);
    assign imem_req  = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rs1       = ir_q[3:2];
    assign rd        = ir_q[3:2];
    assign rs2       = ir_q[1:0];
    assign imm       = imm_q;
    assign alu_op    = in_exec ? dec_alu_op : ALU_ADD;
    assign wb_sel    = in_exec ? dec_wb_sel : WB_ALU;
    assign reg_we    = in_exec && dec_writes_reg;
    assign illegal   = in_exec && dec_is_illegal;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);

`ifdef SCPU_RETIRE_TRACE_EN
    logic [15:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (in_exec) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire     = in_exec;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_scpu_ctrl_fsm.sv
// Scoreboard bench for scpu_ctrl_fsm: an ISA-level model predicts fetch/write/illegal/halt events.
`timescale 1ns/1ps
module tb_scpu_ctrl_fsm;

    localparam int PC_W     = 8;
    localparam int EV_FETCH = 0;
    localparam int EV_WRITE = 1;
    localparam int EV_ILL   = 2;
    localparam int EV_HALT  = 3;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [7:0]      imem_rdata = 8'h00;
    logic            alu_zero;
    logic [1:0]      rs1, rs2, rd, alu_op, wb_sel;
    logic [7:0]      imm;
    logic            reg_we;
    logic [PC_W-1:0] pc;
    logic            busy, halted, illegal;
`ifdef SCPU_RETIRE_TRACE_EN
    logic            retire;
    logic [15:0]     retire_cnt;
`endif

    always #5 clk = ~clk;

    scpu_ctrl_fsm #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_zero   (alu_zero),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .imm        (imm),
        .reg_we     (reg_we),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal)
`ifdef SCPU_RETIRE_TRACE_EN
        ,
        .retire     (retire),
        .retire_cnt (retire_cnt)
`endif
    );

    // Small register-file/ALU datapath so alu_zero and written values are real
    logic [7:0] regs [4];
    logic [7:0] alu_res, wb_val;

    always_comb begin
        alu_res = 8'h00;
        wb_val  = 8'h00;
        case (alu_op)
            2'd0:    alu_res = regs[rs1] + regs[rs2];
            2'd1:    alu_res = regs[rs1] - regs[rs2];
            2'd2:    alu_res = regs[rs1] & regs[rs2];
            default: alu_res = regs[rs1] | regs[rs2];
        endcase
        case (wb_sel)
            2'd1:    wb_val = regs[rs2];
            2'd2:    wb_val = imm;
            default: wb_val = alu_res;
        endcase
    end

    assign alu_zero = (alu_res == 8'h00);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (reg_we) begin
            regs[rd] <= wb_val;
        end
    end

    // Instruction memory responder with fixed or random wait states
    logic [7:0] mem [256];
    int  fixed_wait = 0;
    int  wait_left  = 0;
    bit  spurious   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!imem_req) begin
            wait_left  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            imem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 8'($urandom);
        end else if (wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 8'($urandom);
            wait_left  = wait_left - 1;
        end
    end

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  tracking = 1'b0;
    logic prev_halted = 1'b0;
    int  model_retire = 0;
    bit  model_halted = 1'b0;
    int  model_pc = 0;

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic expect_ev(input int kind, input int a, input int b, input int c, input int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d a=%0h b=%0d c=%0h d=%0d required none", kind, a, b, c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c || e.d != d) begin
                errors++;
                $display("FAIL event got kind=%0d a=%0h b=%0d c=%0h d=%0d required kind=%0d a=%0h b=%0d c=%0h d=%0d",
                         kind, a, b, c, d, e.kind, e.a, e.b, e.c, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tracking) begin
            if (imem_req && imem_ack) expect_ev(EV_FETCH, int'(imem_addr), 0, 0, 0);
            if (reg_we) expect_ev(EV_WRITE, int'(rd), int'(wb_sel), int'(wb_val), int'(alu_op));
            if (illegal) expect_ev(EV_ILL, 0, 0, 0, 0);
            if (halted && !prev_halted) expect_ev(EV_HALT, 0, 0, 0, 0);
        end
        prev_halted <= halted;
    end

    task automatic push_ev(input int kind, input int a, input int b, input int c, input int d);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
        exp_q.push_back(e);
    endtask

    // ISA-level reference: walks the program byte by byte from address 0
    task automatic run_model(input int steps);
        int pcm;
        bit z;
        int r [4];
        int op, opc, dd, ss, immv, res;
        pcm = 0;
        z = 1'b0;
        immv = 0;
        for (int i = 0; i < 4; i++) r[i] = 0;
        model_retire = 0;
        model_halted = 1'b0;
        exp_q.delete();
        for (int n = 0; n < steps && !model_halted; n++) begin
            op = int'(mem[pcm]);
            push_ev(EV_FETCH, pcm, 0, 0, 0);
            pcm = (pcm + 1) % 256;
            opc = op / 16;
            dd  = (op / 4) % 4;
            ss  = op % 4;
            if (opc >= 6 && opc <= 8) begin
                immv = int'(mem[pcm]);
                push_ev(EV_FETCH, pcm, 0, 0, 0);
                pcm = (pcm + 1) % 256;
            end
            if (opc >= 1 && opc <= 4) begin
                case (opc)
                    1:       res = (r[dd] + r[ss]) % 256;
                    2:       res = (r[dd] - r[ss] + 256) % 256;
                    3:       res = r[dd] & r[ss];
                    default: res = r[dd] | r[ss];
                endcase
                push_ev(EV_WRITE, dd, 0, res, opc - 1);
                r[dd] = res;
                z = (res == 0);
            end else if (opc == 5) begin
                push_ev(EV_WRITE, dd, 1, r[ss], 0);
                r[dd] = r[ss];
            end else if (opc == 6) begin
                push_ev(EV_WRITE, dd, 2, immv, 0);
                r[dd] = immv;
            end else if (opc == 7) begin
                pcm = immv;
            end else if (opc == 8) begin
                if (z) pcm = immv;
            end else if (opc == 15) begin
                push_ev(EV_HALT, 0, 0, 0, 0);
                model_halted = 1'b1;
            end else if (opc != 0) begin
                push_ev(EV_ILL, 0, 0, 0, 0);
            end
            if (opc != 15) model_retire++;
        end
        model_pc = pcm;
    endtask

    task automatic do_reset();
        tracking = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic begin_program(input int fw, input bit spur, input int steps);
        fixed_wait = fw;
        spurious   = spur;
        run_model(steps);
        @(negedge clk);
        tracking = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic finish_program(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending events required 0", name, exp_q.size());
        end
        if (model_halted) begin
            repeat (3) @(negedge clk);
            check({name, "_halt_pc"}, int'(pc), model_pc);
            check({name, "_halted"}, int'(halted), 1);
            check({name, "_busy"}, int'(busy), 0);
`ifdef SCPU_RETIRE_TRACE_EN
            check({name, "_retire_cnt"}, int'(retire_cnt), model_retire);
`endif
        end
        tracking = 1'b0;
        $display("program %s done: checks=%0d errors=%0d", name, checks, errors);
    endtask

    task automatic measure_we(output int cycles);
        cycles = 1;
        while (!reg_we && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        int lat;
        int req_seen;

        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_pc", int'(pc), 0);
        check("rst_imem_addr", int'(imem_addr), 0);
        check("rst_req", int'(imem_req), 0);
        check("rst_reg_we", int'(reg_we), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_imm", int'(imm), 0);
        check("rst_rs", int'({rs1, rs2, rd, alu_op, wb_sel}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Reset while stalled in FETCH must clear state in the same cycle
        fill_halt();
        mem[0] = 8'h16;
        fixed_wait = 100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("midfetch_req", int'(imem_req), 1);
        check("midfetch_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_pc", int'(pc), 0);
        check("abort_req", int'(imem_req), 0);
        check("abort_reg_we", int'(reg_we), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD r1,r2 zero-wait: write strobe 3 cycles after start
        fill_halt();
        mem[0] = 8'h16;
        begin_program(0, 1'b0, 10);
        measure_we(lat);
        check("add_latency", lat, 3);
        check("add_rs1", int'(rs1), 1);
        check("add_rs2", int'(rs2), 2);
        check("add_alu_op", int'(alu_op), 0);
        check("add_pc", int'(pc), 1);
        finish_program("add");
        do_reset();

        // LDI r2,0xA5 with two wait states per byte
        fill_halt();
        mem[0] = 8'h68;
        mem[1] = 8'hA5;
        begin_program(2, 1'b0, 10);
        measure_we(lat);
        check("ldi_latency", lat, 8);
        check("ldi_rd", int'(rd), 2);
        check("ldi_wb_sel", int'(wb_sel), 2);
        check("ldi_imm", int'(imm), 8'hA5);
        check("ldi_pc", int'(pc), 2);
        finish_program("ldi");
        do_reset();

        // SUB giving zero then BZ taken
        fill_halt();
        mem[0] = 8'h20;
        mem[1] = 8'h80;
        mem[2] = 8'h10;
        begin_program(0, 1'b0, 10);
        finish_program("bz_taken");
        do_reset();

        // Non-zero SUB then BZ falls through
        fill_halt();
        mem[0] = 8'h64; mem[1] = 8'h05;
        mem[2] = 8'h24;
        mem[3] = 8'h80; mem[4] = 8'h10;
        begin_program(1, 1'b0, 10);
        finish_program("bz_fall");
        do_reset();

        // Illegal opcode then HALT; start must be ignored afterwards
        fill_halt();
        mem[0] = 8'h9C;
        mem[1] = 8'hF0;
        begin_program(0, 1'b1, 10);
        finish_program("illegal_halt");
        req_seen = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) req_seen++;
        end
        start = 1'b0;
        check("halt_start_ignored_req", req_seen, 0);
        check("halt_stays", int'(halted), 1);
        do_reset();

        // PC wrap from 0xFF to 0x00 through a NOP
        fill_halt();
        mem[0] = 8'h80; mem[1] = 8'h10;
        mem[2] = 8'h70; mem[3] = 8'hFE;
        mem[8'hFE] = 8'h20;
        mem[8'hFF] = 8'h00;
        begin_program(0, 1'b0, 20);
        finish_program("pc_wrap");
        do_reset();

        // Randomised programs, random waits and spurious acks
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            begin_program(-1, 1'b1, 40);
            finish_program("random");
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
